rr_arbiter_4: RTL and testbench
===============================

// Module: rr_arbiter_4
// PURPOSE
// - 4-requester round-robin arbiter sharing one resource; the grant is issued
//   one-hot, using the same 2-to-4 decode mapping as the lab decoder
//   (idx 0->4'b0001 ... idx 3->4'b1000).
// - Sits between 4 requesting units and a shared datapath.
// - Bounds hold time so that no requester can starve the others.
// PARAMETERS
// - MAX_HOLD  8  max consecutive cycles one grant may persist (>=2)
// - CNT_W     4  hold counter width; must satisfy 2**CNT_W >= MAX_HOLD
// PORTS
// - clk        in   1  rising-edge clock
// - rst        in   1  asynchronous, active-high reset
// - req        in   4  request vector, bit n = requester n
// - gnt        out  4  one-hot grant, decoded from gnt_idx; 4'b0000 when idle
// - gnt_idx    out  2  index of current/last grantee
// - gnt_valid  out  1  high while gnt is non-zero
// - lock       in   1  present only when ARB_LOCK_EN is defined
// BEHAVIOUR
// - Clocking: single clock clk; rst is asynchronous and active-high.
// - All outputs are registered.
// - Reset values: gnt=0, gnt_idx=0, gnt_valid=0; state=IDLE, hold_cnt=0.
//   Internal last pointer resets to 3, so the first search starts at requester 0.
// - Search: cyclic order last+1, last+2, last+3, last (mod 4 wrap). The first
//   set req bit wins.
// - FSM states: IDLE and GRANT.
//   - IDLE: if req!=0, enter GRANT at the next edge with the searched winner.
//     Latency is 1 cycle from req to gnt.
//   - GRANT: stay in GRANT while req[gnt_idx]=1 and hold_cnt<MAX_HOLD-1.
//     hold_cnt increments each cycle.
//   - Release: when req[gnt_idx]=0 or hold_cnt==MAX_HOLD-1, set last=gnt_idx.
//     Re-search on the same edge using the current req:
//     - req!=0: new grant next cycle (back-to-back handoff, no idle bubble);
//       hold_cnt=0.
//     - req==0: go to IDLE; gnt=0, gnt_valid=0; gnt_idx keeps its old value.
// - Timeout with only the holder still requesting: the same requester is
//   re-granted and hold_cnt restarts at 0. gnt stays continuously high.
// - A requester dropping req while granted frees the resource at the next edge.
// - Simultaneous requests are resolved by the search order only; no fixed
//   priority exists.
// - gnt is always one-hot or zero; gnt_valid == |gnt.
// - Reset mid-grant clears gnt immediately (asynchronously); the search
//   restarts from requester 0.
// - req bits are sampled only at clk edges; glitches between edges are ignored.
// CONFIGURATION
// - ARB_LOCK_EN defined: adds input lock.
//   - While lock=1 in GRANT, the timeout is suppressed: hold_cnt saturates at
//     MAX_HOLD-1 and the grant persists while req[gnt_idx]=1.
//   - Dropping req still releases the grant.
//   - lock is ignored in IDLE.
// - ARB_LOCK_EN undefined: no lock port; the timeout always applies.
// TESTING
// - Reset: rst=1 with req=4'b1111 -> gnt=0, gnt_valid=0. Release rst ->
//   one edge later gnt=4'b0001, gnt_idx=0.
// - Single requester: req=4'b0100 held 3 cycles, then 0 -> gnt=4'b0100 for
//   3 cycles, then 4'b0000 and gnt_valid=0; gnt_idx stays 2.
// - Rotation: req=4'b1111 held, MAX_HOLD=8 -> gnt 0001,0010,0100,1000,0001,
//   each lasting exactly 8 cycles.
// - Handoff: holder 1 drops req while req=4'b1001 -> next cycle gnt=4'b1000
//   (search from 2 wraps to 3), no gap.
// - Wrap: last=3, req=4'b0011 -> gnt=4'b0001.
// - With ARB_LOCK_EN: lock=1, req=4'b0011 for 20 cycles -> gnt=4'b0001 for all
//   20; drop lock -> after hold_cnt expiry, gnt=4'b0010.

Source files
------------

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bus between four requesting units and the rr_arbiter_4 arbiter.
// master: the arbiter side (samples requests, issues grants).
// slave : the requester side (raises requests, observes grants).
// The lock signal exists only when ARB_LOCK_EN is defined.
`timescale 1ns/1ps
interface rr_arbiter_4_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
`ifdef ARB_LOCK_EN
   logic       lock;

   modport master (input req, input lock, output gnt, output gnt_idx, output gnt_valid);
   modport slave  (output req, output lock, input gnt, input gnt_idx, input gnt_valid);
`else
   modport master (input req, output gnt, output gnt_idx, output gnt_valid);
   modport slave  (output req, input gnt, input gnt_idx, input gnt_valid);
`endif
endinterface

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: 4-requester round-robin arbiter with bounded hold time.
// Grant is one-hot (idx 0 -> 4'b0001 ... idx 3 -> 4'b1000), 1-cycle latency,
// back-to-back handoff on release. Optional macro ARB_LOCK_EN adds a lock
// input that suppresses the hold timeout while asserted in GRANT.
`timescale 1ns/1ps
module rr_arbiter_4 #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic          clk,
   input  logic          rst,
   rr_arbiter_4_if.master bus
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   // 2-to-4 one-hot decode of a grant index.
   function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
      logic [3:0] oh;
      case (idx)
         2'd0:    oh = 4'b0001;
         2'd1:    oh = 4'b0010;
         2'd2:    oh = 4'b0100;
         2'd3:    oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

   // Cyclic search last+1, last+2, last+3, last; nearest set bit wins.
   // Walks from the farthest candidate inward so the nearest one overwrites.
   function automatic logic [1:0] rr_search(input logic [3:0] req_v, input logic [1:0] last);
      logic [1:0] win;
      logic [1:0] cand;
      win = last;
      for (int k = 4; k >= 1; k--) begin
         cand = last + 2'(k);
         if (req_v[cand]) begin
            win = cand;
         end else begin
            win = win;
         end
      end
      return win;
   endfunction

   state_e           state_q,     state_d;
   logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
   logic [1:0]       last_q,      last_d;
   logic [1:0]       gnt_idx_q,   gnt_idx_d;
   logic [3:0]       gnt_q,       gnt_d;
   logic             gnt_valid_q, gnt_valid_d;

   logic             lock_s;
   logic             hold_max_s;
   logic [1:0]       search_base_s;
   logic [1:0]       win_s;
   logic             any_req_s;

`ifdef ARB_LOCK_EN
   assign lock_s = bus.lock;
`else
   assign lock_s = 1'b0;
`endif

   assign hold_max_s    = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
   // On release the search starts just after the releasing holder.
   assign search_base_s = (state_q == ST_GRANT) ? gnt_idx_q : last_q;
   assign win_s         = rr_search(bus.req, search_base_s);
   assign any_req_s     = |bus.req;

   // Next-state, hold counter, pointer and grant computation.
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      last_d      = last_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req_s) begin
               state_d     = ST_GRANT;
               gnt_idx_d   = win_s;
               gnt_d       = idx_to_onehot(win_s);
               gnt_valid_d = 1'b1;
               hold_cnt_d  = {CNT_W{1'b0}};
            end else begin
               state_d     = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (!bus.req[gnt_idx_q] || (hold_max_s && !lock_s)) begin
               last_d = gnt_idx_q;
               if (any_req_s) begin
                  // Handoff (or re-grant of a lone holder) with no idle bubble.
                  state_d     = ST_GRANT;
                  gnt_idx_d   = win_s;
                  gnt_d       = idx_to_onehot(win_s);
                  gnt_valid_d = 1'b1;
                  hold_cnt_d  = {CNT_W{1'b0}};
               end else begin
                  // gnt_idx keeps the last grantee while idle.
                  state_d     = ST_IDLE;
                  gnt_d       = 4'b0000;
                  gnt_valid_d = 1'b0;
                  hold_cnt_d  = {CNT_W{1'b0}};
               end
            end else begin
               // Saturation only matters while lock holds the grant past timeout.
               hold_cnt_d = hold_max_s ? hold_cnt_q : (hold_cnt_q + CNT_W'(1));
            end
         end
         default: begin
            state_d     = ST_IDLE;
            hold_cnt_d  = {CNT_W{1'b0}};
            gnt_d       = 4'b0000;
            gnt_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset restarts the search from requester 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         hold_cnt_q  <= {CNT_W{1'b0}};
         last_q      <= 2'd3;
         gnt_idx_q   <= 2'd0;
         gnt_q       <= 4'b0000;
         gnt_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         last_q      <= last_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_idx   = gnt_idx_q;
   assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Testbench for rr_arbiter_4: table of per-cycle {req, expected grant} vectors
// plus hand-written sequences for glitch, async reset mid-grant and lock.
`timescale 1ns/1ps
module tb_rr_arbiter_4;

   logic clk;
   logic rst;

   rr_arbiter_4_if bus ();

   rr_arbiter_4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       valid;
      string      name;
   } vec_t;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       valid;
      string      name;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop if the run ever stalls.
   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] i,
                               input logic v, input string nm);
      vec_t t;
      t.req = r; t.gnt = g; t.idx = i; t.valid = v; t.name = nm;
      vecs.push_back(t);
   endfunction

   task automatic push_exp(input logic [3:0] g, input logic [1:0] i, input logic v, input string nm);
      exp_t e;
      e.gnt = g; e.idx = i; e.valid = v; e.name = nm;
      sb_q.push_back(e);
   endtask

   task automatic compare_front();
      exp_t e;
      n_tests++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard: queue empty, got gnt=%b", bus.gnt);
      end else begin
         e = sb_q.pop_front();
         if (bus.gnt !== e.gnt || bus.gnt_idx !== e.idx || bus.gnt_valid !== e.valid) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b, expected gnt=%b idx=%0d valid=%b",
                     e.name, bus.gnt, bus.gnt_idx, bus.gnt_valid, e.gnt, e.idx, e.valid);
         end
      end
   endtask

   // Drive req on the falling edge, check outputs just after the next rising edge.
   task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] i,
                       input logic v, input string nm);
      @(negedge clk);
      bus.req = r;
      push_exp(g, i, v, nm);
      @(posedge clk);
      #1;
      compare_front();
   endtask

   initial begin
      rst     = 1'b1;
      bus.req = 4'b1111;
`ifdef ARB_LOCK_EN
      bus.lock = 1'b0;
`endif

      // ---- vector table ----
      // Rotation with all requesting: each grant lasts exactly 8 cycles.
      for (int g = 0; g < 4; g++) begin
         for (int c = 0; c < 8; c++) begin
            add(4'b1111, 4'b0001 << g, 2'(g), 1'b1, (c == 0) ? "rot_start" : "rot_hold");
         end
      end
      add(4'b1111, 4'b0001, 2'd0, 1'b1, "rot_wrap");
      add(4'b0000, 4'b0000, 2'd0, 1'b0, "rot_release_idle");
      // Single requester for 3 cycles then drop.
      for (int c = 0; c < 3; c++) add(4'b0100, 4'b0100, 2'd2, 1'b1, "single_gnt");
      for (int c = 0; c < 2; c++) add(4'b0000, 4'b0000, 2'd2, 1'b0, "single_idle_idx");
      // Handoff: holder 1 drops while 0 and 3 request, search from 2 picks 3.
      add(4'b0010, 4'b0010, 2'd1, 1'b1, "handoff_pre");
      add(4'b1001, 4'b1000, 2'd3, 1'b1, "handoff_next");
      add(4'b1001, 4'b1000, 2'd3, 1'b1, "handoff_hold");
      // Wrap: last=3, req=0011 -> requester 0.
      add(4'b0011, 4'b0001, 2'd0, 1'b1, "wrap");
      // Simultaneous requests resolved by search order.
      add(4'b0110, 4'b0010, 2'd1, 1'b1, "simul_a");
      add(4'b0101, 4'b0100, 2'd2, 1'b1, "simul_b");
      // Lone holder times out and is re-granted with the counter restarted.
      for (int c = 0; c < 8; c++) add(4'b0100, 4'b0100, 2'd2, 1'b1, "timeout_regrant");
      for (int c = 0; c < 7; c++) add(4'b0101, 4'b0100, 2'd2, 1'b1, "hold_restarted");
      add(4'b0101, 4'b0001, 2'd0, 1'b1, "timeout_handoff");
      add(4'b0000, 4'b0000, 2'd0, 1'b0, "back_idle");

      // ---- reset state with all requesting ----
      repeat (3) @(posedge clk);
      #1;
      push_exp(4'b0000, 2'd0, 1'b0, "reset_state");
      compare_front();
      #2;
      rst = 1'b0;

      // ---- apply table ----
      foreach (vecs[n]) begin
         step(vecs[n].req, vecs[n].gnt, vecs[n].idx, vecs[n].valid, vecs[n].name);
      end

      // ---- glitch between edges is ignored ----
      #1;
      bus.req = 4'b0001;
      #2;
      bus.req = 4'b0000;
      step(4'b0000, 4'b0000, 2'd0, 1'b0, "glitch_ignored");

      // ---- asynchronous reset mid-grant ----
      step(4'b1000, 4'b1000, 2'd3, 1'b1, "pre_reset_grant");
      #2;
      rst = 1'b1;
      #1;
      push_exp(4'b0000, 2'd0, 1'b0, "async_reset_clear");
      compare_front();
      @(posedge clk);
      #3;
      rst = 1'b0;
      step(4'b1001, 4'b0001, 2'd0, 1'b1, "post_reset_search");
      step(4'b0000, 4'b0000, 2'd0, 1'b0, "post_reset_idle");

`ifdef ARB_LOCK_EN
      // ---- lock suppresses timeout ----
      step(4'b1000, 4'b1000, 2'd3, 1'b1, "lock_prep");
      step(4'b0000, 4'b0000, 2'd3, 1'b0, "lock_prep_idle");
      bus.lock = 1'b1;
      for (int c = 0; c < 20; c++) step(4'b0011, 4'b0001, 2'd0, 1'b1, "lock_hold");
      @(negedge clk);
      bus.lock = 1'b0;
      step(4'b0011, 4'b0010, 2'd1, 1'b1, "lock_release");
      step(4'b0000, 4'b0000, 2'd1, 1'b0, "lock_idle");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
